// File: rtl/eth_tx_pkg.sv
// Shared Ethernet transmit types and wire-timing constants.
// Pure definitions: no logic, no latency, no flow control.
package eth_tx_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, SEND, GAP} tx_arb_state_t;

   localparam int ETH_IFG_BITS        = 96;
   localparam int ETH_MAX_FRAME_BYTES = 1530;
   localparam int ETH_RMII_BITS       = 2;

   localparam int ETH_IFG_CYCLES = ETH_IFG_BITS / ETH_RMII_BITS;
   // Rounded up to a 256-cycle multiple so a legal max-size frame never trips the watchdog.
   localparam int ETH_MAX_FRAME_CYCLES =
      ((ETH_MAX_FRAME_BYTES * 8 / ETH_RMII_BITS + 255) / 256) * 256;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: lowest requesting index after last_grant, wrapping.
// Zero latency; no flow control (any_req says whether winner is meaningful).
module rr_pick #(
   parameter int NUM_REQ = 2,
   localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [LW-1:0]      last_grant,
   output logic [LW-1:0]      winner,
   output logic               any_req
);

   always_comb begin
      logic found;
      int   idx;
      winner  = '0;
      any_req = |req;
      found   = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!found && req[LW'(idx)]) begin
            winner = LW'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Grants the RMII transmit port to one source at a time, muxes its dibits, enforces IFG.
// Grant and data are one cycle behind their inputs; waiting sources simply hold req.
module eth_tx_arbiter
   import eth_tx_pkg::*;
#(
   parameter int N                = ETH_RMII_BITS,
   parameter int NUM_REQ          = 2,
   parameter int IFG_CYCLES       = ETH_IFG_CYCLES,
   parameter int START_TIMEOUT    = 16,
   parameter int MAX_FRAME_CYCLES = ETH_MAX_FRAME_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   src_axiiv,
   input  logic [NUM_REQ*N-1:0] src_axiid,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 eth_txen,
   output logic [N-1:0]         eth_txd,
   output logic                 busy,
   output logic                 aborted
);

   localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(max3(MAX_FRAME_CYCLES, IFG_CYCLES, START_TIMEOUT) + 1);

   tx_arb_state_t      state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic [LW-1:0]      last_grant, last_grant_nxt;
   logic [LW-1:0]      winner;
   logic               any_req;
   logic [NUM_REQ-1:0] grant_nxt;
   logic               txen_nxt;
   logic [N-1:0]       txd_nxt;
   logic               aborted_nxt;
   logic [N-1:0]       src_dat [NUM_REQ];
   logic               cur_vld, cur_req;
   logic [N-1:0]       cur_dat;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req        (req),
      .last_grant (last_grant),
      .winner     (winner),
      .any_req    (any_req)
   );

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
      assign src_dat[i] = src_axiid[i*N +: N];
   end

   // last_grant doubles as the index of the current owner while granted.
   assign cur_vld = src_axiiv[last_grant];
   assign cur_req = req[last_grant];
   assign cur_dat = src_dat[last_grant];
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      grant_nxt      = grant;
      txen_nxt       = 1'b0;
      txd_nxt        = '0;
      aborted_nxt    = 1'b0;
      case (state)
         IDLE: begin
            grant_nxt = '0;
            if (any_req) begin
               grant_nxt[winner] = 1'b1;
               last_grant_nxt    = winner;
               state_nxt         = GRANT;
            end
         end
         GRANT: begin
            if (cur_vld) begin
               txen_nxt  = 1'b1;
               txd_nxt   = cur_dat;
               state_nxt = SEND;
            end else if (!cur_req) begin
               grant_nxt = '0;
               state_nxt = IDLE;
            end else if (cnt == CW'(START_TIMEOUT - 1)) begin
               grant_nxt   = '0;
               aborted_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         SEND: begin
            if (!cur_vld) begin
               grant_nxt = '0;
               state_nxt = GAP;
            end else if (cnt == CW'(MAX_FRAME_CYCLES - 1)) begin
               grant_nxt   = '0;
               aborted_nxt = 1'b1;
               state_nxt   = GAP;
            end else begin
               txen_nxt = 1'b1;
               txd_nxt  = cur_dat;
            end
         end
         GAP: begin
            if (cnt == CW'(IFG_CYCLES - 1)) state_nxt = IDLE;
         end
         default: begin
            grant_nxt = '0;
            state_nxt = IDLE;
         end
      endcase

      if (state_nxt != state || state == IDLE) cnt_nxt = '0;
      else                                     cnt_nxt = cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= LW'(NUM_REQ - 1);
         grant      <= '0;
         eth_txen   <= 1'b0;
         eth_txd    <= '0;
         aborted    <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         last_grant <= last_grant_nxt;
         grant      <= grant_nxt;
         eth_txen   <= txen_nxt;
         eth_txd    <= txd_nxt;
         aborted    <= aborted_nxt;
      end
   end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: single frame, contention, watchdogs, reset, withdrawal.
module tb_eth_tx_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] req;
   logic [1:0] src_axiiv;
   logic [3:0] src_axiid;
   logic [1:0] grant;
   logic       eth_txen;
   logic [1:0] eth_txd;
   logic       busy;
   logic       aborted;

   int n_checks = 0;
   int n_err    = 0;

   eth_tx_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .src_axiiv (src_axiiv),
      .src_axiid (src_axiid),
      .grant     (grant),
      .eth_txen  (eth_txen),
      .eth_txd   (eth_txd),
      .busy      (busy),
      .aborted   (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] dib(input int s, input int k);
      logic [31:0] t;
      t = k * 3 + s * 2 + 1;
      return t[1:0];
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      src_axiiv = '0;
      src_axiid = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Called in the cycle grant[src] first reads high; streams len dibits.
   task automatic send_frame(input int src, input int len, input bit keep_req);
      int         bad;
      logic [1:0] exp_g;
      bad   = 0;
      exp_g = 2'(1 << src);
      src_axiiv[src]          = 1'b1;
      src_axiid[src*2 +: 2]   = dib(src, 0);
      for (int k = 1; k <= len; k++) begin
         tick();
         if (!(eth_txen === 1'b1 && eth_txd === dib(src, k - 1) && grant === exp_g)) bad++;
         if (k < len) src_axiid[src*2 +: 2] = dib(src, k);
         else begin
            src_axiiv[src]        = 1'b0;
            src_axiid[src*2 +: 2] = 2'b00;
            if (!keep_req) req[src] = 1'b0;
         end
      end
      chk("frame_data", 32'(bad), 32'd0);
      tick();
      chk("frame_txen_fall", 32'(eth_txen), 32'd0);
      chk("frame_grant_fall", 32'(grant), 32'd0);
   endtask

   // Called one cycle into GAP (eth_txen just fell).
   task automatic gap_check();
      int bad;
      bad = 0;
      for (int k = 0; k < 47; k++) begin
         tick();
         if (!(eth_txen === 1'b0 && eth_txd === 2'b00 && busy === 1'b1 && aborted === 1'b0)) bad++;
      end
      chk("gap_hold", 32'(bad), 32'd0);
      tick();
      chk("gap_end_busy", 32'(busy), 32'd0);
   endtask

   task automatic wait_grant(output int low);
      low = 1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (eth_txen === 1'b0) low++;
         if (grant !== 2'b00) break;
      end
      chk("grant_wait", 32'(grant != 2'b00), 32'd1);
   endtask

   initial begin
      int low, hi, ab, fall_at, ab_at, bad;
      rst = 1'b1; req = '0; src_axiiv = '0; src_axiid = '0;

      // Reset state
      do_reset();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_txen", 32'(eth_txen), 32'd0);
      chk("rst_txd", 32'(eth_txd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_aborted", 32'(aborted), 32'd0);

      // Single source, 64 dibits
      req = 2'b01;
      tick();
      chk("single_grant", 32'(grant), 32'd1);
      send_frame(0, 64, 1'b0);
      gap_check();

      // Contention from reset: 0,1,0,1 with 50 idle cycles between frames
      req = 2'b11;
      do_reset();
      tick();
      chk("cont_grant0", 32'(grant), 32'd1);
      send_frame(0, 32, 1'b1);
      for (int f = 1; f < 4; f++) begin
         wait_grant(low);
         chk("cont_low_cycles", 32'(low), 32'd50);
         chk("cont_grant", 32'(grant), 32'(1 << (f % 2)));
         send_frame(f % 2, 32, 1'b1);
      end
      req = 2'b00;

      // Start timeout on source 1, source 0 pending
      do_reset();
      req = 2'b10;
      tick();
      chk("to_grant1", 32'(grant), 32'd2);
      req[0] = 1'b1;
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (!(grant === 2'b10 && aborted === 1'b0 && eth_txen === 1'b0)) bad++;
      end
      chk("to_wait", 32'(bad), 32'd0);
      tick();
      chk("to_grant_drop", 32'(grant), 32'd0);
      chk("to_aborted", 32'(aborted), 32'd1);
      chk("to_txen", 32'(eth_txen), 32'd0);
      req[1] = 1'b0;
      tick();
      chk("to_next_grant", 32'(grant), 32'd1);
      chk("to_abort_pulse", 32'(aborted), 32'd0);
      send_frame(0, 8, 1'b0);
      gap_check();

      // Runaway source 1
      req = 2'b10;
      tick();
      chk("run_grant", 32'(grant), 32'd2);
      src_axiiv[1] = 1'b1;
      src_axiid[3:2] = dib(1, 0);
      hi = 0; ab = 0; fall_at = -1; ab_at = -1;
      for (int i = 1; i <= 7000 && fall_at < 0; i++) begin
         tick();
         src_axiid[3:2] = dib(1, i);
         if (eth_txen === 1'b1) hi++;
         else if (fall_at < 0) fall_at = i;
         if (aborted === 1'b1) begin
            ab++;
            ab_at = i;
         end
      end
      chk("run_hi_cycles", 32'(hi), 32'd6144);
      chk("run_abort_count", 32'(ab), 32'd1);
      chk("run_abort_at_fall", 32'(ab_at == fall_at), 32'd1);
      chk("run_grant_drop", 32'(grant), 32'd0);
      req = 2'b00;
      gap_check();
      src_axiiv = '0;
      src_axiid = '0;

      // Reset mid-SEND of source 0 (last_grant is 1 here)
      req = 2'b01;
      tick();
      chk("rs_grant0", 32'(grant), 32'd1);
      src_axiiv[0] = 1'b1;
      src_axiid[1:0] = dib(0, 0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         src_axiid[1:0] = dib(0, k);
      end
      rst = 1'b1;
      tick();
      chk("rs_txen", 32'(eth_txen), 32'd0);
      chk("rs_grant", 32'(grant), 32'd0);
      chk("rs_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      src_axiiv = '0;
      src_axiid = '0;
      req = 2'b11;
      tick();
      chk("rs_next_grant", 32'(grant), 32'd1);

      // Withdrawal: source 0 immediately, then source 1 three cycles into GRANT
      req[0] = 1'b0;
      tick();
      chk("wd0_grant", 32'(grant), 32'd0);
      chk("wd0_busy", 32'(busy), 32'd0);
      tick();
      chk("wd1_grant", 32'(grant), 32'd2);
      tick();
      tick();
      chk("wd1_hold", 32'(grant), 32'd2);
      req[1] = 1'b0;
      tick();
      chk("wd1_grant_drop", 32'(grant), 32'd0);
      chk("wd1_busy", 32'(busy), 32'd0);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (!(aborted === 1'b0 && busy === 1'b0 && eth_txen === 1'b0)) bad++;
      end
      chk("wd1_no_abort", 32'(bad), 32'd0);
      req[1] = 1'b1;
      tick();
      chk("wd1_regrant", 32'(grant), 32'd2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
